// File: rtl/alu_op_queue_pkg.sv
// alu_pkg: shared widths, instruction/response packing and stage states.
package alu_pkg;

  localparam int OPC_W   = 3;
  localparam int SRC_W   = 4;
  localparam int RES_W   = 6;
  localparam int INSTR_W = 11;
  localparam int RESP_W  = 8;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [SRC_W-1:0] src_a;
    logic [SRC_W-1:0] src_b;
  } instr_t;

  typedef struct packed {
    logic [RES_W-1:0] alu_out;
    logic             overflow;
    logic             zero;
  } resp_t;

  typedef enum logic {ISS_EMPTY, ISS_LIVE} iss_state_t;
  typedef enum logic {RES_EMPTY, RES_HELD} res_state_t;

`ifdef ALU_QUEUE_STATS_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == '1) ? v : v + 8'd1;
  endfunction
`endif

endpackage

// File: rtl/alu_op_fifo.sv
// alu_op_fifo: DEPTH-entry instruction FIFO with flush and occupancy count.
// Caller guarantees push only when not full and pop only when not empty.
module alu_op_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  input  logic           push,
  input  logic           pop,
  input  instr_t         wr_data,
  output instr_t         rd_data,
  output logic [PTR_W:0] count
);

  instr_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_queue.sv
// alu_op_queue: instruction queue feeding a combinational ALU, with an issue
// register and a result register. Optional stats counters: ALU_QUEUE_STATS_EN.
module alu_op_queue
  import alu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_data,
  output logic [OPC_W-1:0]   opcode,
  output logic [SRC_W-1:0]   src_a,
  output logic [SRC_W-1:0]   src_b,
  output logic               iss_valid,
  input  logic [RES_W-1:0]   alu_out,
  input  logic               overflow,
  input  logic               zero,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [RESP_W-1:0]  res_data,
  output logic [PTR_W:0]     count
`ifdef ALU_QUEUE_STATS_EN
  ,
  output logic [7:0]         ovf_cnt,
  output logic [7:0]         zero_cnt
`endif
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  iss_state_t iss_state, iss_next;
  res_state_t res_state, res_next;
  instr_t     head;
  resp_t      resp;
  logic       push, pop, iss_load, res_load;

  assign in_ready  = (count != FULL_CNT);
  assign iss_valid = (iss_state == ISS_LIVE);
  assign res_valid = (res_state == RES_HELD);
  assign res_load  = iss_valid && (!res_valid || res_ready);
  assign iss_load  = (count != '0) && (!iss_valid || res_load);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = iss_load && !flush;
  assign resp      = '{alu_out: alu_out, overflow: overflow, zero: zero};

  alu_op_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .push    (push),
    .pop     (pop),
    .wr_data (instr_t'(in_data)),
    .rd_data (head),
    .count   (count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iss_state <= ISS_EMPTY;
      res_state <= RES_EMPTY;
    end else begin
      iss_state <= iss_next;
      res_state <= res_next;
    end
  end

  always_comb begin
    iss_next = iss_state;
    res_next = res_state;
    if (flush) begin
      iss_next = ISS_EMPTY;
      res_next = RES_EMPTY;
    end else begin
      if (iss_load) begin
        iss_next = ISS_LIVE;
      end else if (res_load) begin
        iss_next = ISS_EMPTY;
      end
      if (res_load) begin
        res_next = RES_HELD;
      end else if (res_valid && res_ready) begin
        res_next = RES_EMPTY;
      end
    end
  end

  // Data registers only; flush leaves their contents as-is.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opcode   <= '0;
      src_a    <= '0;
      src_b    <= '0;
      res_data <= '0;
    end else if (!flush) begin
      if (iss_load) begin
        opcode <= head.opcode;
        src_a  <= head.src_a;
        src_b  <= head.src_b;
      end
      if (res_load) begin
        res_data <= resp;
      end
    end
  end

`ifdef ALU_QUEUE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_cnt  <= '0;
      zero_cnt <= '0;
    end else if (flush) begin
      ovf_cnt  <= '0;
      zero_cnt <= '0;
    end else if (res_load) begin
      if (overflow) begin
        ovf_cnt <= sat_inc(ovf_cnt);
      end
      if (zero) begin
        zero_cnt <= sat_inc(zero_cnt);
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_queue.sv
// tb_alu_op_queue: directed bench with a stub ALU and an ordered result model.
module tb_alu_op_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] in_data;
  logic [2:0]  opcode;
  logic [3:0]  src_a;
  logic [3:0]  src_b;
  logic        iss_valid;
  logic [5:0]  alu_out;
  logic        overflow;
  logic        zero;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_data;
  logic [3:0]  count;
`ifdef ALU_QUEUE_STATS_EN
  logic [7:0]  ovf_cnt;
  logic [7:0]  zero_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  // Stub ALU
  assign alu_out  = {2'b00, src_a} + {2'b00, src_b};
  assign overflow = 1'b0;
  assign zero     = (alu_out == 6'd0);

  alu_op_queue #(
    .DEPTH (8),
    .PTR_W (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .opcode    (opcode),
    .src_a     (src_a),
    .src_b     (src_b),
    .iss_valid (iss_valid),
    .alu_out   (alu_out),
    .overflow  (overflow),
    .zero      (zero),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .count     (count)
`ifdef ALU_QUEUE_STATS_EN
    ,
    .ovf_cnt   (ovf_cnt),
    .zero_cnt  (zero_cnt)
`endif
  );

  function automatic logic [7:0] model(input logic [10:0] ins);
    int s;
    s = int'(ins[7:4]) + int'(ins[3:0]);
    return {6'(s), 1'b0, (s == 0)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Sampled 2 time units before each rising edge: accepted pushes enter the
  // model, accepted results are compared in order.
  always begin
    @(posedge clk);
    #8;
    if (reset || flush) begin
      exp_q.delete();
    end else begin
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL res_stream: got %0h expected none", res_data);
        end else begin
          check("res_stream", 32'(res_data), 32'(exp_q.pop_front()));
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_data));
      end
    end
  end

  initial begin
    int first;
    int last;
    int nres;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    check("rst_count", 32'(count), 0);
    check("rst_iss_valid", 32'(iss_valid), 0);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_res_data", 32'(res_data), 0);
    check("rst_alu_in", 32'({opcode, src_a, src_b}), 0);
`ifdef ALU_QUEUE_STATS_EN
    check("rst_zero_cnt", 32'(zero_cnt), 0);
`endif
    tick();
    check("rst_in_ready", 32'(in_ready), 1);

    // Single op: 3 + 5
    res_ready = 1'b1;
    in_valid = 1'b1; in_data = {3'b000, 4'd3, 4'd5};
    tick();
    in_valid = 1'b0;
    check("single_n_iss", 32'(iss_valid), 0);
    tick();
    check("single_n1_iss", 32'(iss_valid), 1);
    check("single_n1_src_a", 32'(src_a), 3);
    check("single_n1_src_b", 32'(src_b), 5);
    check("single_n1_res_valid", 32'(res_valid), 0);
    tick();
    check("single_n2_res_valid", 32'(res_valid), 1);
    check("single_n2_res_data", 32'(res_data), 32'h20);
    tick();
    check("single_drained", 32'(res_valid), 0);

    // Streaming: 20 back-to-back
    first = -1; last = -1; nres = 0;
    for (int c = 0; c < 30; c++) begin
      in_valid = (c < 20);
      in_data  = {3'(c), 4'(c * 5), 4'(c * 3)};
      tick();
      if (res_valid) begin
        nres++;
        if (first < 0) first = c;
        last = c;
      end
    end
    in_valid = 1'b0;
    check("stream_nres", 32'(nres), 20);
    check("stream_first", 32'(first), 2);
    check("stream_no_bubble", 32'(last - first), 19);

    // Full/backpressure: 10 ops with result stalled
    res_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = {3'(i), 4'(15 - i), 4'(9 + i)};
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("full_count", 32'(count), 8);
    check("full_in_ready", 32'(in_ready), 0);
    check("full_iss_valid", 32'(iss_valid), 1);
    check("full_res_valid", 32'(res_valid), 1);
    check("full_res_hold", 32'(res_data), 32'({6'd24, 2'b00}));
    in_valid = 1'b1; in_data = {3'd7, 4'd1, 4'd1};
    tick();
    check("full_no_push", 32'(count), 8);
    check("full_res_stable", 32'(res_data), 32'({6'd24, 2'b00}));
    // Release with a push pending: the pop edge must not accept it
    res_ready = 1'b1; in_data = {3'd0, 4'd15, 4'd15};
    tick();
    check("full_pop_count", 32'(count), 7);
    check("full_in_ready_rise", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    check("full_push_after", 32'(count), 7);
    repeat (14) tick();
    check("full_drain_count", 32'(count), 0);
    check("full_drain_res", 32'(res_valid), 0);
    check("full_model_empty", 32'(exp_q.size()), 0);

    // Zero flag
    in_valid = 1'b1; in_data = {3'b000, 4'd0, 4'd0};
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    check("zero_res_valid", 32'(res_valid), 1);
    check("zero_res_data", 32'(res_data), 32'h01);
    tick();

    // Flush with work everywhere and a concurrent push
    res_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = {3'(i), 4'(i + 1), 4'(2 * i)};
      tick();
    end
    check("preflush_count", 32'(count), 5);
    check("preflush_iss", 32'(iss_valid), 1);
    check("preflush_res", 32'(res_valid), 1);
    flush = 1'b1; in_valid = 1'b1; in_data = {3'd1, 4'd2, 4'd3};
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_count", 32'(count), 0);
    check("flush_iss", 32'(iss_valid), 0);
    check("flush_res", 32'(res_valid), 0);
    check("flush_src_keep", 32'(src_a), 2);
    res_ready = 1'b1;
    repeat (3) tick();
    check("flush_lost_count", 32'(count), 0);
    check("flush_lost_res", 32'(res_valid), 0);
    in_valid = 1'b1; in_data = {3'd2, 4'd1, 4'd2};
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    check("postflush_res", 32'(res_data), 32'({6'd3, 2'b00}));

`ifdef ALU_QUEUE_STATS_EN
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1; in_data = '0;
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    check("stats_zero_sat", 32'(zero_cnt), 255);
    check("stats_ovf", 32'(ovf_cnt), 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("stats_flush", 32'(zero_cnt), 0);
`endif

    // Async reset mid-stream
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = {3'(i), 4'(i + 4), 4'(i + 7)};
      tick();
    end
    reset = 1'b1;
    in_valid = 1'b0;
    #1;
    check("areset_count", 32'(count), 0);
    check("areset_iss", 32'(iss_valid), 0);
    check("areset_res", 32'(res_valid), 0);
    check("areset_res_data", 32'(res_data), 0);
    check("areset_alu_in", 32'({opcode, src_a, src_b}), 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    tick();
    check("areset_in_ready", 32'(in_ready), 1);
    in_valid = 1'b1; in_data = {3'd4, 4'd9, 4'd6};
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    check("postreset_res", 32'(res_data), 32'({6'd15, 2'b00}));

    repeat (4) tick();
    check("final_model_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
